// File: rtl/lsu_req_ctrl.sv
// Purpose: single-outstanding load/store master between execute stage and LSU AR/R/AW/W/B channels.
// Latency: accept T, bus valids T+1, resp_valid T+3 minimum with always-ready LSU and writeback.
// Backpressure: req_ready only in IDLE; bus valids held until handshake; response held until resp_ready.
module lsu_req_ctrl #(
  parameter bit CHECK_ALIGN = 1'b1,
  parameter bit BUS_ERR_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mtype,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic [2:0]  mrtypeM,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic        aw_done, w_done;

  logic        is_half, is_word, bad_type, misalign, illegal;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] ld_ext;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;

  assign araddr = addr_q;
  assign awaddr = addr_q;

  // Classify the incoming request: access size, legality of mtype, alignment.
  always_comb begin
    is_half  = (req_mtype == 3'd1) || (!req_wen && req_mtype == 3'd4);
    is_word  = (req_mtype == 3'd2);
    bad_type = req_wen ? (req_mtype > 3'd2) : (req_mtype > 3'd4);
    misalign = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    illegal  = bad_type || (CHECK_ALIGN && misalign);
  end

  // Place store data on the byte lanes selected by the low address bits.
  always_comb begin
    lane_wstrb = 4'b1111;
    lane_wdata = req_wdata;
    case (req_mtype)
      3'd0: begin
        lane_wstrb = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      3'd1: begin
        lane_wstrb = 4'b0011 << {req_addr[1], 1'b0};
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_wstrb = 4'b1111;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // The R beat carries the full aligned word; pick the addressed lane and extend it.
  always_comb begin
    rd_shift = rdata >> {addr_q[1:0], 3'b000};
    rd_half  = addr_q[1] ? rdata[31:16] : rdata[15:0];
    ld_ext   = rdata;
    case (mrtypeM)
      3'd0:    ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    ld_ext = {{16{rd_half[15]}}, rd_half};
      3'd3:    ld_ext = {24'd0, rd_shift[7:0]};
      3'd4:    ld_ext = {16'd0, rd_half};
      default: ld_ext = rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and handshake outputs; all valids/readies are decoded from state.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (illegal)      state_d = S_RESP;
          else if (req_wen) state_d = S_WR_ADDR_DATA;
          else              state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_d = S_RESP;
      end
      S_WR_ADDR_DATA: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, per-channel write completion flags and response capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= 32'd0;
      mrtypeM    <= 3'd0;
      wdata      <= 32'd0;
      wstrb      <= 4'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            mrtypeM    <= req_wen ? 3'd0 : req_mtype;
            wdata      <= lane_wdata;
            wstrb      <= lane_wstrb;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= illegal;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            resp_err   <= rresp && BUS_ERR_EN;
            resp_rdata <= (rresp && BUS_ERR_EN) ? 32'd0 : ld_ext;
          end
        end
        S_WR_ADDR_DATA: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
        S_WR_RESP: begin
          if (bvalid) begin
            resp_err   <= bresp && BUS_ERR_EN;
            resp_rdata <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Purpose: self-checking bench for lsu_req_ctrl with directed vectors and random traffic.
// Latency: LSU and writeback are modelled with per-transaction ready/valid delays.
// Backpressure: stalls on AR/AW/W, delayed R/B beats and delayed resp_ready are exercised.
module tb_lsu_req_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mtype;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  mrtypeM;
  logic        arvalid, arready, rresp, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  lsu_req_ctrl #(.CHECK_ALIGN(1'b1), .BUS_ERR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mtype(req_mtype),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .mrtypeM(mrtypeM), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [2:0]  mtype;
    logic [31:0] mem;
    logic        berr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        illegal;
    int          lat_a, lat_w, lat_d, lat_r;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdat,
                              input logic [2:0] mtype, input logic [31:0] mem, input logic berr,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                              input logic illegal, input int la, input int lw, input int ld, input int lr);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdat = wdat; v.mtype = mtype; v.mem = mem; v.berr = berr;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata;
    v.illegal = illegal; v.lat_a = la; v.lat_w = lw; v.lat_d = ld; v.lat_r = lr;
    return v;
  endfunction

  // Reference model: access size from mtype, legality from address modulo size,
  // lane values by byte arithmetic on the full memory word.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     size, off;
    bit     sgn;
    longint val, mask;
    r = v; size = 0; sgn = 0; off = int'(v.addr[1:0]);
    if (v.wen) begin
      case (v.mtype)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (v.mtype)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd3: size = 1;
        3'd4: size = 2;
        default: size = 0;
      endcase
    end
    r.illegal = (size == 0) ? 1'b1 : ((off % size) != 0);
    r.exp_rdata = 32'd0; r.exp_err = 1'b0; r.exp_wstrb = 4'd0; r.exp_wdata = 32'd0;
    mask = (size == 0) ? 64'd0 : ((64'd1 << (8 * size)) - 64'd1);
    if (r.illegal) begin
      r.exp_err = 1'b1;
    end else if (v.wen) begin
      r.exp_wstrb = 4'(((1 << size) - 1) << off);
      val = 0;
      for (int i = 0; i < 4 / size; i++) val = val | ((longint'({32'd0, v.wdat}) & mask) << (8 * size * i));
      r.exp_wdata = val[31:0];
      r.exp_err = v.berr;
    end else if (v.berr) begin
      r.exp_err = 1'b1;
    end else begin
      val = (longint'({32'd0, v.mem}) >> (8 * off)) & mask;
      if (sgn && val >= (longint'(1) << (8 * size - 1))) val = val - (longint'(1) << (8 * size));
      r.exp_rdata = val[31:0];
    end
    return r;
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_mtype = 0;
    resp_ready = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
  endtask

  // Run one transaction acting as LSU and writeback. Entered and left on a negedge.
  task automatic do_txn(input vec_t v);
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, d_cnt = 0, rs_cnt = 0, first_cyc = 0;
    bit ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, done = 0, seen = 0;
    bit ar_pend = 0, aw_pend = 0, w_pend = 0;
    bit ar_now, r_now, aw_now, w_now, b_now;
    logic [31:0] held_rdata;
    logic        held_err;
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdat; req_mtype = v.mtype;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_mtype = 3'($urandom);
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (v.illegal) chk("no_bus_traffic", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
      if (ar_pend) chk("arvalid_held", arvalid, 1'b1);
      if (aw_pend) chk("awvalid_held", awvalid, 1'b1);
      if (w_pend)  chk("wvalid_held", wvalid, 1'b1);
      if (ar_hs && arvalid) chk("arvalid_after_hs", arvalid, 1'b0);
      if (aw_hs && awvalid) chk("awvalid_after_hs", awvalid, 1'b0);
      if (w_hs && wvalid)   chk("wvalid_after_hs", wvalid, 1'b0);
      if (arvalid) begin ar_cnt++; chk("araddr", araddr, v.addr); end
      if ((arvalid || (ar_hs && !r_hs)) && !v.wen) chk("mrtypeM", {29'd0, mrtypeM}, {29'd0, v.mtype});
      if (awvalid) begin aw_cnt++; chk("awaddr", awaddr, v.addr); end
      if (wvalid) begin
        w_cnt++;
        chk("wdata", wdata, v.exp_wdata);
        chk("wstrb", {28'd0, wstrb}, {28'd0, v.exp_wstrb});
      end
      arready = arvalid && (ar_cnt > v.lat_a);
      awready = awvalid && (aw_cnt > v.lat_a);
      wready  = wvalid && (w_cnt > v.lat_w);
      if (ar_hs && !r_hs) begin
        d_cnt++;
        rvalid = (d_cnt > v.lat_d); rdata = v.mem; rresp = v.berr;
      end else rvalid = 0;
      if (aw_hs && w_hs && !b_hs) begin
        d_cnt++;
        bvalid = (d_cnt > v.lat_d); bresp = v.berr;
      end else bvalid = 0;
      if (resp_valid) begin
        if (!seen) begin
          seen = 1; first_cyc = cyc;
          chk("resp_rdata", resp_rdata, v.exp_rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, v.exp_err});
          held_rdata = resp_rdata; held_err = resp_err;
        end else begin
          chk("resp_rdata_stable", resp_rdata, held_rdata);
          chk("resp_err_stable", {31'd0, resp_err}, {31'd0, held_err});
        end
        rs_cnt++;
        resp_ready = (rs_cnt > v.lat_r);
        if (resp_ready) done = 1;
      end else resp_ready = 0;
      ar_now = arvalid && arready; aw_now = awvalid && awready; w_now = wvalid && wready;
      r_now = rvalid && rready; b_now = bvalid && bready;
      ar_pend = arvalid && !ar_now; aw_pend = awvalid && !aw_now; w_pend = wvalid && !w_now;
      if (ar_now) ar_hs = 1;
      if (r_now)  r_hs = 1;
      if (aw_now) aw_hs = 1;
      if (w_now)  w_hs = 1;
      if (b_now)  b_hs = 1;
    end
    if (!done) begin
      chk("txn_timeout", 32'd0, 32'd1);
      rst = 0; @(negedge clk); rst = 1;
    end else if (v.lat_a == 0 && v.lat_w == 0 && v.lat_d == 0) begin
      chk("resp_latency", first_cyc, v.illegal ? 32'd1 : 32'd3);
    end
    @(negedge clk);
    idle_inputs();
    chk("resp_released", resp_valid, 1'b0);
  endtask

  initial begin
    vec_t v;
    //         wen addr          wdat          mt  mem           be  exp_rdata     er  strb  exp_wdata     ill la lw ld lr
    vecs[0]  = mk(0, 32'h8000_0010, 32'h0,        0+2, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 4'h0, 32'h0,        0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 32'h8000_0020, 32'h0,        0,   32'h0000_0080, 0, 32'hFFFF_FF80, 0, 4'h0, 32'h0,        0, 0, 0, 2, 0);
    vecs[2]  = mk(0, 32'h8000_0020, 32'h0,        3,   32'h0000_0080, 0, 32'h0000_0080, 0, 4'h0, 32'h0,        0, 1, 0, 1, 0);
    vecs[3]  = mk(0, 32'h8000_0040, 32'h0,        1,   32'h0000_9234, 0, 32'hFFFF_9234, 0, 4'h0, 32'h0,        0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 32'h8000_0040, 32'h0,        4,   32'h0000_9234, 0, 32'h0000_9234, 0, 4'h0, 32'h0,        0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 32'h8000_0043, 32'h0,        0,   32'h7F00_0000, 0, 32'h0000_007F, 0, 4'h0, 32'h0,        0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 32'h8000_0046, 32'h0,        1,   32'h8001_7FFF, 0, 32'hFFFF_8001, 0, 4'h0, 32'h0,        0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 32'h8000_0103, 32'hFFFF_FF5A, 0,  32'h0,         0, 32'h0,         0, 4'h8, 32'h5A5A_5A5A, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 32'h8000_0102, 32'h0000_1234, 1,  32'h0,         0, 32'h0,         0, 4'hC, 32'h1234_1234, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 32'h8000_0104, 32'hCAFE_F00D, 2,  32'h0,         0, 32'h0,         0, 4'hF, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 32'h8000_0108, 32'h1122_3344, 2,  32'h0,         0, 32'h0,         0, 4'hF, 32'h1122_3344, 0, 3, 0, 0, 0);
    vecs[11] = mk(0, 32'h8000_0012, 32'h0,        2,   32'h0,         0, 32'h0,         1, 4'h0, 32'h0,        1, 0, 0, 0, 4);
    vecs[12] = mk(0, 32'h8000_0011, 32'h0,        1,   32'h0,         0, 32'h0,         1, 4'h0, 32'h0,        1, 0, 0, 0, 0);
    vecs[13] = mk(1, 32'h8000_0103, 32'h0,        1,   32'h0,         0, 32'h0,         1, 4'h0, 32'h0,        1, 0, 0, 0, 0);
    vecs[14] = mk(0, 32'h8000_0000, 32'h0,        5,   32'h0,         0, 32'h0,         1, 4'h0, 32'h0,        1, 0, 0, 0, 0);
    vecs[15] = mk(1, 32'h8000_0000, 32'h0,        3,   32'h0,         0, 32'h0,         1, 4'h0, 32'h0,        1, 0, 0, 0, 0);
    vecs[16] = mk(1, 32'h8000_0200, 32'h0000_0055, 2,  32'h0,         1, 32'h0,         1, 4'hF, 32'h0000_0055, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 32'h8000_0300, 32'h0,        2,   32'h1234_5678, 1, 32'h0,         1, 4'h0, 32'h0,        0, 0, 0, 0, 0);

    idle_inputs();
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
    chk("rst_mrtypeM", {29'd0, mrtypeM}, 32'd0);
    chk("rst_resp", {resp_rdata[30:0], resp_err}, 32'd0);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) do_txn(vecs[i]);

    // Reset while waiting for the R beat: transaction abandoned, no response.
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0400; req_mtype = 3'd2;
    @(negedge clk);
    req_valid = 0;
    chk("mid_arvalid", arvalid, 1'b1);
    arready = 1;
    @(negedge clk);
    arready = 0;
    chk("mid_rready", rready, 1'b1);
    rst = 0;
    @(negedge clk);
    chk("mid_rst_valids", {29'd0, arvalid, rready, resp_valid}, 32'd0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_araddr", araddr, 32'd0);
    rst = 1; rvalid = 1; rdata = 32'hFFFF_FFFF; resp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_no_resp", {30'd0, rready, resp_valid}, 32'd0);
    end
    idle_inputs();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      v.wen = 1'($urandom_range(0, 1));
      v.addr = $urandom;
      v.wdat = $urandom;
      v.mtype = 3'($urandom_range(0, 5));
      v.mem = $urandom;
      v.berr = ($urandom_range(0, 7) == 0);
      v.lat_a = $urandom_range(0, 3);
      v.lat_w = $urandom_range(0, 3);
      v.lat_d = $urandom_range(0, 3);
      v.lat_r = $urandom_range(0, 2);
      v = model(v);
      do_txn(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
